hazard_scoreboard: RTL and testbench

Parametrised hazard scoreboard for the five-stage MIPS pipeline, the sequential successor to the combinational decode of `rsTuse`/`rtTuse`/`Tnew`. It holds one entry per in-flight stage after D (default E, M, W) with destination address and remaining Tnew. Every cycle it compares the D-stage operands against those entries and produces the D-stage stall, the D-stage forward selects and a saturating stall counter. It sits beside the decoder in D and drives the F/D enable and the D/E bubble insert.

---
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage hazard scoreboard: stall, forward selects, stall counter.
// Optional MDU interlock enabled by defining HAZARD_SCOREBOARD_MDU_EN.
module hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int AW     = 5,
  parameter int TW     = 3,
  parameter int CW     = 16,
  localparam int FSW   = $clog2(STAGES + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr,
  input  logic [AW-1:0]  d_rs,
  input  logic [AW-1:0]  d_rt,
  input  logic [TW-1:0]  d_rs_tuse,
  input  logic [TW-1:0]  d_rt_tuse,
  input  logic [AW-1:0]  d_a3,
  input  logic           d_rfen,
  input  logic [TW-1:0]  d_tnew,
  input  logic           d_md,
  input  logic           d_md_start,
  input  logic           mdu_busy,
  output logic           stall,
  output logic [FSW-1:0] fwd_rs_sel,
  output logic [FSW-1:0] fwd_rt_sel,
  output logic [CW-1:0]  stall_cnt
);

  logic [STAGES-1:0] v;
  logic [AW-1:0]     a3   [STAGES];
  logic [TW-1:0]     tnew [STAGES];
  logic              data_stall;
  logic              md_stall;

  // Walk from oldest to youngest so the youngest match overwrites the selects.
  always_comb begin
    data_stall = 1'b0;
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (v[i] && (a3[i] != '0) && (a3[i] == d_rs)) begin
        if (tnew[i] > d_rs_tuse) data_stall = 1'b1;
        fwd_rs_sel = (tnew[i] == '0) ? FSW'(i + 1) : '0;
      end
      if (v[i] && (a3[i] != '0) && (a3[i] == d_rt)) begin
        if (tnew[i] > d_rt_tuse) data_stall = 1'b1;
        fwd_rt_sel = (tnew[i] == '0) ? FSW'(i + 1) : '0;
      end
    end
  end

`ifdef HAZARD_SCOREBOARD_MDU_EN
  logic e_md_start;

  always_ff @(posedge clk) begin
    if (!reset || clr) e_md_start <= 1'b0;
    else               e_md_start <= d_md_start & ~stall;
  end

  assign md_stall = d_md & (mdu_busy | e_md_start);
`else
  logic unused_md;
  assign unused_md = ^{d_md, d_md_start, mdu_busy};
  assign md_stall  = 1'b0;
`endif

  assign stall = data_stall | md_stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v         <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < STAGES; i++) begin
        a3[i]   <= '0;
        tnew[i] <= '0;
      end
    end else begin
      // The counter sees a stall even in a flush cycle.
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CW'(1);
      if (clr) begin
        v <= '0;
      end else begin
        v[0]    <= stall ? 1'b0 : d_rfen;
        a3[0]   <= stall ? '0 : d_a3;
        tnew[0] <= (stall || (d_tnew == '0)) ? '0 : d_tnew - TW'(1);
        for (int i = 1; i < STAGES; i++) begin
          v[i]    <= v[i-1];
          a3[i]   <= a3[i-1];
          tnew[i] <= (tnew[i-1] == '0) ? '0 : tnew[i-1] - TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
  logic       clk = 1'b0;
  logic       reset, clr;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [2:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       d_rfen, d_md, d_md_start, mdu_busy;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
  logic [3:0] stall_cnt;
  int         vecs = 0;
  int         errs = 0;
  logic [3:0] exp_cnt;

  hazard_scoreboard #(.STAGES(3), .AW(5), .TW(3), .CW(4)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_a3(d_a3), .d_rfen(d_rfen), .d_tnew(d_tnew),
    .d_md(d_md), .d_md_start(d_md_start), .mdu_busy(mdu_busy),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; d_rs = '0; d_rt = '0; d_rs_tuse = 3'd5; d_rt_tuse = 3'd5;
    d_a3 = '0; d_rfen = 1'b0; d_tnew = '0; d_md = 1'b0; d_md_start = 1'b0; mdu_busy = 1'b0;
  endtask

  task automatic flush();
    idle();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; idle();
    d_rs_tuse = '0; d_rt_tuse = '0;
    repeat (2) tick();
    reset = 1'b1;
    @(negedge clk);
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %0b want 0", stall); end
    vecs++; if (fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin errs++; $display("FAIL reset_sel got %0d/%0d want 0/0", fwd_rs_sel, fwd_rt_sel); end
    vecs++; if (stall_cnt !== 4'd0) begin errs++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    tick();
  endtask

  task automatic test_load_use();
    flush();
    d_a3 = 5'd8; d_tnew = 3'd3; d_rfen = 1'b1;
    @(negedge clk);
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL lw_issue_stall got %0b want 0", stall); end
    tick();
    idle(); d_rs = 5'd8; d_rs_tuse = 3'd1;
    @(negedge clk);
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL lw_use_stall got %0b want 1", stall); end
    tick();
    @(negedge clk);
    vecs++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd0) begin errs++; $display("FAIL lw_after_stall got stall=%0b sel=%0d want 0/0", stall, fwd_rs_sel); end
    tick();
    @(negedge clk);
    vecs++; if (fwd_rs_sel !== 2'd3) begin errs++; $display("FAIL lw_fwd_w got %0d want 3", fwd_rs_sel); end
    vecs++; if (stall_cnt !== 4'd1) begin errs++; $display("FAIL lw_cnt got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_youngest();
    flush();
    d_a3 = 5'd9; d_tnew = 3'd2; d_rfen = 1'b1;
    tick();
    tick();
    idle(); d_rt = 5'd9; d_rt_tuse = 3'd0;
    @(negedge clk);
    vecs++; if (stall !== 1'b1 || fwd_rt_sel !== 2'd0) begin errs++; $display("FAIL beq_stall got stall=%0b sel=%0d want 1/0", stall, fwd_rt_sel); end
    tick();
    @(negedge clk);
    vecs++; if (stall !== 1'b0 || fwd_rt_sel !== 2'd2) begin errs++; $display("FAIL beq_fwd got stall=%0b sel=%0d want 0/2", stall, fwd_rt_sel); end
    vecs++; if (fwd_rs_sel !== 2'd0) begin errs++; $display("FAIL beq_rs_sel got %0d want 0", fwd_rs_sel); end
    vecs++; if (stall_cnt !== 4'd2) begin errs++; $display("FAIL beq_cnt got %0d want 2", stall_cnt); end
    tick();
  endtask

  task automatic test_zero_reg();
    flush();
    d_a3 = 5'd0; d_tnew = 3'd3; d_rfen = 1'b1;
    tick();
    idle(); d_rs = 5'd0; d_rs_tuse = 3'd0; d_rt = 5'd0; d_rt_tuse = 3'd0;
    @(negedge clk);
    vecs++; if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin errs++; $display("FAIL zero_reg got stall=%0b sel=%0d/%0d want 0/0/0", stall, fwd_rs_sel, fwd_rt_sel); end
    tick();
  endtask

  task automatic test_mdu();
    logic exp_st;
`ifdef HAZARD_SCOREBOARD_MDU_EN
    exp_st = 1'b1;
`else
    exp_st = 1'b0;
`endif
    flush();
    d_md = 1'b1; d_md_start = 1'b1;
    @(negedge clk);
    vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL mdu_start got %0b want 0", stall); end
    tick();
    d_md_start = 1'b0;
    @(negedge clk);
    vecs++; if (stall !== exp_st) begin errs++; $display("FAIL mdu_estart got %0b want %0b", stall, exp_st); end
    tick();
    mdu_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vecs++; if (stall !== exp_st) begin errs++; $display("FAIL mdu_busy%0d got %0b want %0b", k, stall, exp_st); end
      tick();
    end
    idle();
    exp_cnt = exp_st ? 4'd8 : 4'd2;
    @(negedge clk);
    vecs++; if (stall !== 1'b0 || stall_cnt !== exp_cnt) begin errs++; $display("FAIL mdu_cnt got stall=%0b cnt=%0d want 0/%0d", stall, stall_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_saturate_clr();
    flush();
    for (int it = 0; it < 7; it++) begin
      idle(); d_a3 = 5'd10; d_tnew = 3'd7; d_rfen = 1'b1;
      tick();
      idle(); d_rs = 5'd10; d_rs_tuse = 3'd0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL sat_stall%0d_%0d got %0b want 1", it, k, stall); end
        tick();
      end
    end
    idle();
    @(negedge clk);
    vecs++; if (stall_cnt !== 4'd15) begin errs++; $display("FAIL sat_cnt got %0d want 15", stall_cnt); end
    d_a3 = 5'd11; d_tnew = 3'd3; d_rfen = 1'b1;
    tick();
    idle(); d_rt = 5'd11; d_rt_tuse = 3'd0; clr = 1'b1;
    @(negedge clk);
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL clr_stall got %0b want 1", stall); end
    tick();
    clr = 1'b0;
    @(negedge clk);
    vecs++; if (stall !== 1'b0 || fwd_rt_sel !== 2'd0) begin errs++; $display("FAIL clr_flush got stall=%0b sel=%0d want 0/0", stall, fwd_rt_sel); end
    vecs++; if (stall_cnt !== 4'd15) begin errs++; $display("FAIL clr_cnt got %0d want 15", stall_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    flush();
    d_a3 = 5'd12; d_tnew = 3'd3; d_rfen = 1'b1;
    tick();
    idle(); d_rs = 5'd12; d_rs_tuse = 3'd0;
    @(negedge clk);
    vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL rst_pre_stall got %0b want 1", stall); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    vecs++; if (stall !== 1'b0 || stall_cnt !== 4'd0) begin errs++; $display("FAIL rst_mid got stall=%0b cnt=%0d want 0/0", stall, stall_cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_youngest();
    test_zero_reg();
    test_mdu();
    test_saturate_clr();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
